uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Byte FIFO directly downstream of the UART receiver. Captures each received byte on the
//   receiver's one-cycle completion strobe and holds it until the consumer pops it with a
//   valid/ready handshake. Flags overflow when a byte arrives while the FIFO is full.
//   Single clock domain, shared with the receiver.
// PARAMETERS
//   DEPTH   16   number of byte entries; power of two, >= 2
//   ADDR_W  4    log2(DEPTH); pointer width. Occupancy count is ADDR_W+1 bits.
// PORTS
//   clk       in   1         system clock, rising edge
//   rst       in   1         reset; one clock; asynchronous, active-high
//   wr_data   in   8         received byte, connected to receiver rx_dout
//   wr_en     in   1         1-cycle write strobe, connected to receiver rx_comp
//   rd_data   out  8         head-of-queue byte; 8'h00 when empty
//   rd_valid  out  1         head byte available (= !empty)
//   rd_ready  in   1         consumer accepts head byte when rd_valid&rd_ready
//   count     out  ADDR_W+1  current occupancy, 0..DEPTH
//   full      out  1         count == DEPTH
//   empty     out  1         count == 0
//   overflow  out  1         sticky: a write was dropped because the FIFO was full
//   ovf_clr   in   1         1-cycle clear for overflow
// BEHAVIOUR
//   Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0, overflow=0 -> empty=1,
//     full=0, rd_valid=0, rd_data=8'h00. Storage array is not reset.
//   Outputs full, empty, rd_valid and count are registered, or decoded from registered
//     count. rd_data is first-word fall-through: combinational read of mem[rd_ptr], gated
//     to 8'h00 when empty.
//   Push: wr_en && (!full || pop) -> mem[wr_ptr]<=wr_data, wr_ptr+1 mod DEPTH.
//   Pop:  rd_valid && rd_ready -> rd_ptr+1 mod DEPTH. rd_ready while empty is ignored.
//   Count: +1 on push only, -1 on pop only, unchanged on push and pop together.
//   Latency: byte written at edge N is visible on rd_data/rd_valid after edge N (one cycle).
//   No same-cycle bypass from empty.
//   Boundary cases:
//     full + wr_en + pop -> both occur; count stays DEPTH; no overflow.
//     full + wr_en, no pop -> byte dropped; contents/pointers unchanged; overflow<=1.
//     empty + wr_en + rd_ready -> write accepted, no pop; count becomes 1.
//     Pointer wrap DEPTH-1 -> 0 is seamless; full/empty come from count, not pointer compare.
//     overflow set and ovf_clr in the same cycle -> set wins (overflow stays 1).
//     overflow never clears by itself; only ovf_clr or rst clears it.
//   wr_en is expected to be a single-cycle pulse. A level held high writes every cycle; the
//     block does not edge-detect.
//   Reset mid-operation: contents discarded, state returns to reset values immediately.
//   No byte is presented after reset until a new write.
// TESTING
//   1 Reset: assert rst mid-stream with count=5 -> count=0, empty=1, rd_valid=0,
//     rd_data=8'h00, overflow=0.
//   2 Ordering: write 8'hA5, 8'h3C, 8'hFF (pulses 10 clk apart), rd_ready=0 -> count=3,
//     rd_data=8'hA5; then rd_ready=1 -> pops A5, 3C, FF in order, then empty=1.
//   3 Fill/overflow: 16 writes 8'h00..8'h0F, then write 8'h99 with rd_ready=0 -> full=1,
//     count=16, overflow=1; drain yields 00..0F only (no 99).
//   4 Full with simultaneous push+pop: at count=16, wr_en(8'h77)+rd_ready in one cycle ->
//     count=16, overflow=0, 8'h77 emerges last.
//   5 Wrap: 40 random bytes with random rd_ready throttling, never exceeding 16 in flight ->
//     output sequence == input sequence, count matches the scoreboard every cycle.
//   6 Overflow clear: overflow=1, pulse ovf_clr -> 0 next cycle; ovf_clr in the same cycle as
//     a dropped write -> overflow stays 1.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: write strobe, read handshake and status bundle for the UART receive FIFO
interface uart_rx_fifo_if #(parameter int ADDR_W = 4);
    logic [7:0]    wr_data;
    logic          wr_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [ADDR_W:0] count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          ovf_clr;
    modport master (
        output wr_data, wr_en, rd_ready, ovf_clr,
        input  rd_data, rd_valid, count, full, empty, overflow
    );
    modport slave (
        input  wr_data, wr_en, rd_ready, ovf_clr,
        output rd_data, rd_valid, count, full, empty, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through byte FIFO behind the UART receiver with sticky overflow
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic            clk,
    input logic            rst,
    uart_rx_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              ovf;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic              drop;
    // status decode and handshake qualification; a pop frees the slot a full-FIFO write needs
    always_comb begin
        full  = cnt == FULL_CNT;
        empty = cnt == '0;
        pop   = !empty && bus.rd_ready;
        push  = bus.wr_en && (!full || pop);
        drop  = bus.wr_en && full && !pop;
    end
    // storage is deliberately left unreset; contents are only meaningful below count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end
    // pointers, occupancy and sticky overflow; a dropped write beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            cnt <= (push && !pop) ? cnt + (ADDR_W+1)'(1) :
                   (pop && !push) ? cnt - (ADDR_W+1)'(1) : cnt;
            ovf <= drop ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf;
        end
    end
    assign bus.rd_data  = empty ? 8'h00 : mem[rd_ptr];
    assign bus.rd_valid = !empty;
    assign bus.count    = cnt;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.overflow = ovf;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized scenario bench for uart_rx_fifo against a queue-based model
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_err = 0;
    logic [7:0] q[$];
    logic m_ovf = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.ADDR_W(4)) bus ();
    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [7:0] m_head();
        return q.size() > 0 ? q[0] : 8'h00;
    endfunction

    // one clock with the given inputs; the model advances by the FIFO's stated rules
    task automatic cyc(input logic we, input logic [7:0] wd, input logic rr, input logic oc);
        bit pop, drop;
        bus.wr_en = we; bus.wr_data = wd; bus.rd_ready = rr; bus.ovf_clr = oc;
        @(posedge clk);
        pop  = q.size() > 0 && rr;
        drop = we && q.size() == 16 && !pop;
        if (pop) void'(q.pop_front());
        if (we && !drop) q.push_back(wd);
        m_ovf = drop ? 1'b1 : oc ? 1'b0 : m_ovf;
        #1;
        bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.rd_ready = 1'b0; bus.ovf_clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_chk++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        n_chk++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", bus.full); end
        n_chk++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.rd_valid); end
        n_chk++; if (bus.rd_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", bus.rd_data); end
        n_chk++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_order();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hA5; exp_b[1] = 8'h3C; exp_b[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, exp_b[i], 1'b0, 1'b0);
            n_chk++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL order_latency got %b want 1", bus.rd_valid); end
            repeat (9) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        end
        n_chk++; if (bus.count !== 5'd3) begin n_err++; $display("FAIL order_count got %0d want 3", bus.count); end
        n_chk++; if (bus.rd_data !== 8'hA5) begin n_err++; $display("FAIL order_head got %h want a5", bus.rd_data); end
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (bus.rd_data !== exp_b[i]) begin n_err++; $display("FAIL order_pop%0d got %h want %h", i, bus.rd_data, exp_b[i]); end
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_chk++; if (bus.empty !== 1'b1 || bus.rd_data !== 8'h00) begin n_err++; $display("FAIL order_empty got %b/%h want 1/00", bus.empty, bus.rd_data); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        n_chk++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", bus.full); end
        n_chk++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL fill_count got %0d want 16", bus.count); end
        n_chk++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL fill_ovf got %b want 1", bus.overflow); end
        for (int i = 0; i < 16; i++) begin
            n_chk++; if (bus.rd_data !== 8'(i)) begin n_err++; $display("FAIL fill_drain%0d got %h want %h", i, bus.rd_data, 8'(i)); end
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_chk++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL fill_no99 got valid=%b data=%h want 0", bus.rd_valid, bus.rd_data); end
        n_chk++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL fill_sticky got %b want 1", bus.overflow); end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        n_chk++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL fpp_count got %0d want 16", bus.count); end
        n_chk++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fpp_ovf got %b want 0", bus.overflow); end
        n_chk++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fpp_full got %b want 1", bus.full); end
        for (int i = 0; i < 16; i++) begin
            n_chk++; if (bus.rd_data !== m_head()) begin n_err++; $display("FAIL fpp_drain%0d got %h want %h", i, bus.rd_data, m_head()); end
            if (i == 15) begin
                n_chk++; if (bus.rd_data !== 8'h77) begin n_err++; $display("FAIL fpp_last got %h want 77", bus.rd_data); end
            end
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] in_q[$];
        logic [7:0] out_q[$];
        logic we, rr;
        logic [7:0] d;
        int sent = 0;
        int cycles = 0;
        while ((sent < 40 || out_q.size() < 40) && cycles < 2000) begin
            we = sent < 40 && q.size() < 16 && $urandom_range(0, 1) == 1;
            rr = $urandom_range(0, 2) != 0;
            d  = 8'($urandom);
            n_chk++; if (bus.rd_valid !== (q.size() > 0)) begin n_err++; $display("FAIL wrap_valid got %b want %b", bus.rd_valid, q.size() > 0); end
            if (rr && q.size() > 0) begin
                n_chk++; if (bus.rd_data !== q[0]) begin n_err++; $display("FAIL wrap_data got %h want %h", bus.rd_data, q[0]); end
                out_q.push_back(bus.rd_data);
            end
            if (we) begin in_q.push_back(d); sent++; end
            cyc(we, d, rr, 1'b0);
            n_chk++; if (bus.count !== 5'(q.size())) begin n_err++; $display("FAIL wrap_count got %0d want %0d", bus.count, q.size()); end
            cycles++;
        end
        n_chk++; if (cycles >= 2000) begin n_err++; $display("FAIL wrap_timeout got %0d cycles want <2000", cycles); end
        n_chk++; if (out_q.size() != in_q.size()) begin n_err++; $display("FAIL wrap_len got %0d want %0d", out_q.size(), in_q.size()); end
        for (int i = 0; i < in_q.size() && i < out_q.size(); i++) begin
            n_chk++; if (out_q[i] !== in_q[i]) begin n_err++; $display("FAIL wrap_seq%0d got %h want %h", i, out_q[i], in_q[i]); end
        end
    endtask

    task automatic test_ovf_clr();
        for (int i = 0; i < 17; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        n_chk++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL clr_set got %b want 1", bus.overflow); end
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        n_chk++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL clr_hold got %b want 1", bus.overflow); end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        n_chk++; if (bus.overflow !== m_ovf) begin n_err++; $display("FAIL clr_clear got %b want %b", bus.overflow, m_ovf); end
        cyc(1'b1, 8'h42, 1'b0, 1'b1);
        n_chk++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL clr_setwins got %b want 1", bus.overflow); end
        n_chk++; if (bus.count !== 5'(q.size())) begin n_err++; $display("FAIL clr_count got %0d want %0d", bus.count, q.size()); end
    endtask

    task automatic test_reset_mid();
        repeat (11) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        n_chk++; if (bus.count !== 5'd5) begin n_err++; $display("FAIL rmid_pre got %0d want 5", bus.count); end
        #2 rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        n_chk++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL rmid_count got %0d want 0", bus.count); end
        n_chk++; if (bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rmid_empty got %b/%b want 1/0", bus.empty, bus.rd_valid); end
        n_chk++; if (bus.rd_data !== 8'h00) begin n_err++; $display("FAIL rmid_data got %h want 00", bus.rd_data); end
        n_chk++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rmid_ovf got %b want 0", bus.overflow); end
        @(negedge clk) rst = 1'b0;
        repeat (3) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            n_chk++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale got %b want 0", bus.rd_valid); end
        end
    endtask

    task automatic test_empty_wr_rd();
        cyc(1'b1, 8'h5A, 1'b1, 1'b0);
        n_chk++; if (bus.count !== 5'd1) begin n_err++; $display("FAIL ewr_count got %0d want 1", bus.count); end
        n_chk++; if (bus.rd_data !== 8'h5A || bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL ewr_head got %h/%b want 5a/1", bus.rd_data, bus.rd_valid); end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.rd_ready = 1'b0; bus.ovf_clr = 1'b0;
        test_reset();
        test_order();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_ovf_clr();
        test_reset_mid();
        test_empty_wr_rd();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
